tx_byte_fifo: RTL and testbench

// Byte FIFO and start sequencer between the process stage and the UART transmitter.
// It accepts bytes from process (data_out/data_valid) at clk_9_6M rate and buffers them.
// It presents one byte at a time to the transmitter, using a level start / tx_ready handshake.

---
 rtl/tx_byte_fifo_if.sv | 47 ++++
 rtl/tx_byte_fifo.sv | 127 ++++++++++++
 tb/tb_tx_byte_fifo.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tx_byte_fifo_if.sv
// tx_byte_fifo_if: groups the write-side and transmitter-side signals of tx_byte_fifo.
//   slave  modport: FIFO view (takes wr_valid/wr_data/tx_ready, drives status and tx_*).
//   master modport: producer/transmitter view (the opposite directions).
//   wr_valid/wr_data : byte strobe and data from the process stage
//   full/empty/count/overflow : FIFO status
//   tx_data/tx_start/tx_ready : level handshake with the UART transmitter
//   busy : sequencer not idle
interface tx_byte_fifo_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_ready;
    logic              busy;

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  tx_ready,
        output full,
        output empty,
        output count,
        output overflow,
        output tx_data,
        output tx_start,
        output busy
    );

    modport master (
        output wr_valid,
        output wr_data,
        output tx_ready,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  tx_data,
        input  tx_start,
        input  busy
    );
endinterface

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: byte FIFO plus start sequencer between the process stage and the UART
// transmitter. Bytes are pushed on wr_valid strobes and handed to the transmitter one at
// a time with a level tx_start that is held until the transmitter drops tx_ready.
//   clk  : clk_9_6M, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : tx_byte_fifo_if.slave (write strobe/data, status, transmitter handshake)
module tx_byte_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    tx_byte_fifo_if.slave      bus
);

    typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             mem_q [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic rdy_s;
    logic full, empty;
    logic push, pop, drop;

    // tx_ready comes from the uart_clk domain; only the last sync stage is used.
    assign rdy_s = sync_q[SYNC_STAGES-1];
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Sequencer: one byte in flight; the next pop waits for DRAIN -> IDLE.
    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty && rdy_s) begin
                    pop        = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = StReq;
                end
            end
            StReq: begin
                // Hold start until the transmitter acknowledges by going busy.
                if (!rdy_s) begin
                    tx_start_d = 1'b0;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (rdy_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FIFO bookkeeping; a pop frees a slot in the same cycle, so a full FIFO still
    // accepts a write when it pops.
    always_comb begin
        push       = bus.wr_valid && (!full || pop);
        drop       = bus.wr_valid && !push;
        wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            sync_q[0]  <= bus.tx_ready;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_tx_byte_fifo.sv
// tb_tx_byte_fifo: directed bench for tx_byte_fifo. A per-cycle vector table covers reset
// and a single-byte handshake; hand-written sequences with a small transmitter model cover
// burst, overflow, full-with-pop and reset mid-transfer.
module tb_tx_byte_fifo;

    logic clk;
    logic rst;

    tx_byte_fifo_if #(.ADDR_W(4)) bus ();

    tx_byte_fifo #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Transmitter model control/state
    logic       model_en  = 1'b0;
    logic       hold      = 1'b0;
    logic       tb_ready  = 1'b1;
    logic       mdl_ready = 1'b1;
    int         busy_clks = 1000;
    int         busy_cnt  = 0;
    logic [7:0] sent_q[$];

    assign bus.tx_ready = model_en ? mdl_ready : tb_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model transmitter: captures tx_data when it sees start while idle, then stays busy.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (busy_cnt > 0) begin
                busy_cnt--;
                mdl_ready = 1'b0;
            end else if (model_en && bus.tx_start && mdl_ready) begin
                sent_q.push_back(bus.tx_data);
                mdl_ready = 1'b0;
                busy_cnt  = busy_clks;
            end else begin
                mdl_ready = !hold;
            end
        end
    end

    task automatic wait_sent(input string name, input int n, input int limit);
        int cyc = 0;
        while (!(sent_q.size() >= n && !bus.busy && busy_cnt == 0 && mdl_ready) && cyc < limit) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk({name, "_sent"}, sent_q.size(), n);
    endtask

    typedef struct {
        logic       rst;
        logic       wv;
        logic [7:0] wd;
        logic       rdy;
        logic       e_start;
        logic [7:0] e_data;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_busy;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[13];

    initial begin
        //            rst  wv    wd     rdy  start data   cnt   empty full busy ovf
        vecs[0]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;

        // Reset and single-byte handshake, one row per clock
        for (int i = 0; i < 13; i++) begin
            rst          = vecs[i].rst;
            bus.wr_valid = vecs[i].wv;
            bus.wr_data  = vecs[i].wd;
            tb_ready     = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_start", i), bus.tx_start, vecs[i].e_start);
            chk($sformatf("v%0d_data", i),  bus.tx_data,  vecs[i].e_data);
            chk($sformatf("v%0d_count", i), bus.count,    vecs[i].e_count);
            chk($sformatf("v%0d_empty", i), bus.empty,    vecs[i].e_empty);
            chk($sformatf("v%0d_full", i),  bus.full,     vecs[i].e_full);
            chk($sformatf("v%0d_busy", i),  bus.busy,     vecs[i].e_busy);
            chk($sformatf("v%0d_ovf", i),   bus.overflow, vecs[i].e_ovf);
        end
        bus.wr_valid = 1'b0;

        // Burst of five bytes against a slow transmitter
        sent_q.delete();
        busy_clks = 1000;
        hold      = 1'b0;
        model_en  = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        chk("burst_count_peak", bus.count, 5'd4);
        wait_sent("burst", 5, 8000);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("burst_byte%0d", i), sent_q[i], 8'(i + 1));
        end
        chk("burst_ovf", bus.overflow, 1'b0);

        // Overflow: transmitter held busy, 17 writes into 16 entries
        sent_q.delete();
        busy_clks = 20;
        hold      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h10 + 8'(i);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        chk("ovf_count", bus.count, 5'd16);
        chk("ovf_full", bus.full, 1'b1);
        chk("ovf_flag", bus.overflow, 1'b1);
        chk("ovf_nostart", bus.tx_start, 1'b0);

        // Full + pop in the same cycle: keep offering 77 until the pop edge
        hold = 1'b0;
        begin
            int cyc = 0;
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h77;
            do begin
                @(posedge clk);
                #1;
                cyc++;
            end while (!bus.busy && cyc < 20);
            bus.wr_valid = 1'b0;
            chk("fullpop_popped", bus.busy, 1'b1);
        end
        chk("fullpop_count", bus.count, 5'd16);
        chk("fullpop_ovf", bus.overflow, 1'b1);
        wait_sent("ovf", 17, 2000);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_byte%0d", i), sent_q[i], 8'h10 + 8'(i));
        end
        chk("fullpop_last", sent_q[16], 8'h77);

        // Reset mid-transfer with bytes queued
        model_en = 1'b0;
        tb_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h31 + 8'(i);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        chk("mid_req_start", bus.tx_start, 1'b1);
        chk("mid_req_count", bus.count, 5'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_start", bus.tx_start, 1'b0);
        chk("mid_rst_empty", bus.empty, 1'b1);
        chk("mid_rst_count", bus.count, 5'd0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ovf", bus.overflow, 1'b0);
        begin
            int starts = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (bus.tx_start) starts++;
            end
            chk("mid_quiet", starts, 0);
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h3C;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        chk("mid_new_lat1", bus.tx_start, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_new_start", bus.tx_start, 1'b1);
        chk("mid_new_data", bus.tx_data, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
